// File: rtl/eight_bit_accumulator.sv
// rtl/eight_bit_accumulator.sv - batch accumulator folding an 8-bit operand stream through eight_bit_adder

// Combinational 8-bit adder with carry in/out.
module eight_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);

  logic [8:0] full;

  // Nine-bit add so the carry-out falls out as the top bit.
  always_comb begin
    full      = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
    sum       = full[7:0];
    carry_out = full[8];
  end

endmodule

// Accumulates N_OPS operands per batch, then offers the result on a
// valid/ready port. All outputs come from registers or the state register.
module eight_bit_accumulator #(
  parameter int N_OPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic [7:0] out_carry_count,
  output logic       out_overflow
);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam logic [7:0] LAST_OP = 8'(N_OPS - 1);

  state_t     state;
  logic [7:0] acc;
  logic [7:0] carry_cnt;
  logic [7:0] op_cnt;
  logic [7:0] add_sum;
  logic       add_carry;

  eight_bit_adder u_adder (
    .a         (acc),
    .b         (in_data),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // Batch FSM: reset and clear both abort; otherwise accept operands in
  // ACCUM and hold the result in DONE until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= ACCUM;
      acc       <= 8'd0;
      carry_cnt <= 8'd0;
      op_cnt    <= 8'd0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= add_sum;
            if (add_carry && (carry_cnt != 8'hFF)) begin
              carry_cnt <= carry_cnt + 8'd1;
            end
            if (op_cnt == LAST_OP) begin
              op_cnt <= 8'd0;
              state  <= DONE;
            end else begin
              op_cnt <= op_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc       <= 8'd0;
            carry_cnt <= 8'd0;
            op_cnt    <= 8'd0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Handshake flags decode straight from the state; result fields come
  // from the registers unconditionally since they are don't-care in ACCUM.
  always_comb begin
    in_ready        = (state == ACCUM);
    out_valid       = (state == DONE);
    out_sum         = acc;
    out_carry_count = carry_cnt;
    out_overflow    = |carry_cnt;
  end

endmodule

// File: tb/tb_eight_bit_accumulator.sv
// tb/tb_eight_bit_accumulator.sv - self-checking bench for eight_bit_accumulator
module tb_eight_bit_accumulator;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_overflow;
  logic [7:0] out_sum, out_carry_count;

  logic       in_valid1, out_ready1;
  logic [7:0] in_data1;
  logic       in_ready1, out_valid1, out_overflow1;
  logic [7:0] out_sum1, out_carry_count1;

  always #5 clk = ~clk;

  eight_bit_accumulator #(.N_OPS(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry_count(out_carry_count), .out_overflow(out_overflow)
  );

  eight_bit_accumulator #(.N_OPS(1)) dut1 (
    .clk(clk), .reset(reset), .clear(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_carry_count(out_carry_count1), .out_overflow(out_overflow1)
  );

  typedef struct {
    logic [3:0][7:0] ops;
    int              gap;
    logic [7:0]      exp_sum;
    logic [7:0]      exp_cc;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic [7:0] cc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic last_in_ready;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int gap, input logic [7:0] s,
                              input logic [7:0] cc);
    vec_t v;
    v.ops[0] = a; v.ops[1] = b; v.ops[2] = c; v.ops[3] = d;
    v.gap = gap; v.exp_sum = s; v.exp_cc = cc;
    return v;
  endfunction

  function automatic exp_t model(input logic [3:0][7:0] ops);
    exp_t e;
    logic [8:0] t;
    e.sum = 8'd0; e.cc = 8'd0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, e.sum} + {1'b0, ops[i]};
      e.sum = t[7:0];
      if (t[8] && e.cc != 8'hFF) e.cc = e.cc + 8'd1;
    end
    return e;
  endfunction

  // One clock cycle: sample at the falling edge (scoreboard pop on a real
  // handshake), then step to just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_in_ready = in_ready;
    if (out_valid && out_ready && !clear && !reset) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_sum", int'(out_sum), int'(e.sum));
        chk("out_carry_count", int'(out_carry_count), int'(e.cc));
        chk("out_overflow", int'(out_overflow), int'(e.cc != 8'd0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_in_ready && n < 50);
    if (!last_in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic send_batch(input logic [3:0][7:0] ops, input int gap);
    for (int i = 0; i < 4; i++) begin
      send(ops[i]);
      if (i < 3) idle(gap);
    end
    chk("latency_out_valid", int'(out_valid), 1);
  endtask

  initial begin
    exp_t e;
    logic [3:0][7:0] rops;

    tbl[0] = mk(8'd100, 8'd12,  8'd99,  8'd45,  0, 8'd0,   8'd1);
    tbl[1] = mk(8'd127, 8'd127, 8'd127, 8'd127, 0, 8'd252, 8'd1);
    tbl[2] = mk(8'd255, 8'd1,   8'd255, 8'd1,   0, 8'd0,   8'd2);
    tbl[3] = mk(8'd1,   8'd2,   8'd3,   8'd4,   0, 8'd10,  8'd0);
    tbl[4] = mk(8'd10,  8'd20,  8'd30,  8'd40,  2, 8'd100, 8'd0);
    tbl[5] = mk(8'd255, 8'd255, 8'd255, 8'd255, 0, 8'd252, 8'd3);

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = 8'd0; out_ready1 = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_carry_count", int'(out_carry_count), 0);
    chk("rst_out_overflow", int'(out_overflow), 0);

    // Table vectors, results collected through the scoreboard.
    for (int i = 0; i < 6; i++) begin
      e.sum = tbl[i].exp_sum; e.cc = tbl[i].exp_cc;
      sb.push_back(e);
      send_batch(tbl[i].ops, tbl[i].gap);
    end
    drain();

    // Random batches checked against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) rops[i] = 8'($urandom_range(0, 255));
      sb.push_back(model(rops));
      send_batch(rops, r % 2);
    end
    drain();

    // Backpressure: result held, offered operands ignored.
    out_ready = 1'b0;
    e.sum = 8'd26; e.cc = 8'd0;
    sb.push_back(e);
    send_batch({8'd8, 8'd7, 8'd6, 8'd5}, 0);
    in_valid = 1'b1; in_data = 8'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_sum", int'(out_sum), 26);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("bp_in_ready_after", int'(in_ready), 1);
    e.sum = 8'd10; e.cc = 8'd0;
    sb.push_back(e);
    send_batch({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    drain();

    // Reset mid-batch discards partial sum.
    send(8'd200);
    send(8'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_sum", int'(out_sum), 0);
    e.sum = 8'd10; e.cc = 8'd0;
    sb.push_back(e);
    send_batch({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    drain();

    // Clear in DONE with out_ready high: result dropped, no handshake.
    out_ready = 1'b0;
    send_batch({8'd9, 8'd9, 8'd9, 8'd9}, 0);
    out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_out_valid", int'(out_valid), 0);
    chk("clear_in_ready", int'(in_ready), 1);
    chk("clear_out_sum", int'(out_sum), 0);
    e.sum = 8'd4; e.cc = 8'd1;
    sb.push_back(e);
    send_batch({8'd80, 8'd70, 8'd60, 8'd50}, 0);
    drain();

    // N_OPS=1: each operand is its own result, carry count 0.
    in_valid1 = 1'b1; in_data1 = 8'd200;
    tick();
    chk("n1_out_valid", int'(out_valid1), 1);
    chk("n1_in_ready", int'(in_ready1), 0);
    chk("n1_out_sum", int'(out_sum1), 200);
    chk("n1_carry", int'(out_carry_count1), 0);
    in_data1 = 8'd250;
    tick();
    chk("n1_back_in_ready", int'(in_ready1), 1);
    tick();
    chk("n1_out_sum2", int'(out_sum1), 250);
    chk("n1_carry2", int'(out_carry_count1), 0);
    chk("n1_overflow2", int'(out_overflow1), 0);
    in_valid1 = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
